// File: rtl/serial_target_pkg.sv
// ============================================================================
// Module  : serial_target_pkg
// Brief   : Shared frame sizes, bus mode encoding and port FSM states.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package serial_target_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int CNT_W  = $clog2(ADDR_W);
  localparam int SER_W  = $clog2(DATA_W);

  typedef enum logic {
    MODE_ADDR = 1'b0,
    MODE_DATA = 1'b1
  } bus_mode_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    DATA      = 3'd2,
    REQ       = 3'd3,
    WAIT_ACK  = 3'd4,
    SHIFT_OUT = 3'd5
  } port_state_e;

endpackage

`default_nettype wire

// File: rtl/target_mem.sv
// ============================================================================
// Module  : target_mem
// Brief   : Byte RAM with single-cycle request/ack handshake. Optional
//           reset-clear of the array via SERIAL_TARGET_MEM_CLEAR_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module target_mem
  import serial_target_pkg::*;
#(
  parameter int INTERNAL_ADDR_BITS = 11
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          addr_valid,
  input  logic                          data_valid,
  input  logic                          rw,
  input  logic [INTERNAL_ADDR_BITS-1:0] addr,
  input  logic [DATA_W-1:0]             data_in,
  output logic                          ack,
  output logic                          ready,
  output logic [DATA_W-1:0]             data_out,
  output logic                          data_out_valid
);

  localparam int DEPTH = 2 ** INTERNAL_ADDR_BITS;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_ack;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic              w_wr_en;
  logic              w_rd_en;

  assign w_wr_en = addr_valid & data_valid & rw & ready;
  assign w_rd_en = addr_valid & ~rw & ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack      <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_ack      <= w_wr_en | w_rd_en;
      r_rd_valid <= w_rd_en;
      if (w_rd_en) begin
        r_rd_data <= r_mem[addr];
      end
    end
  end

`ifdef SERIAL_TARGET_MEM_CLEAR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[addr] <= data_in;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[addr] <= data_in;
    end
  end
`endif

  // Busy only during the ack cycle, so ready is the inverse of ack.
  assign ack            = r_ack;
  assign ready          = ~r_ack;
  assign data_out       = r_rd_data;
  assign data_out_valid = r_rd_valid;

endmodule

`default_nettype wire

// File: rtl/serial_target.sv
// ============================================================================
// Module  : serial_target
// Brief   : Bit-serial bus slave: deserialises address/data into byte memory
//           requests and serialises read data back. SERIAL_TARGET_MEM_CLEAR_EN
//           clears the memory on reset.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_target
  import serial_target_pkg::*;
#(
  parameter int INTERNAL_ADDR_BITS = 11
) (
  input  logic clk,
  input  logic rst_n,
  input  logic decoder_valid,
  input  logic bus_data_in,
  input  logic bus_data_in_valid,
  input  logic bus_mode,
  input  logic target_rw,
  output logic bus_data_out,
  output logic bus_data_out_valid,
  output logic bus_target_ready,
  output logic bus_target_rw,
  output logic bus_target_ack
);

  port_state_e       r_state;
  port_state_e       w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_ser_byte;
  logic [SER_W-1:0]  r_ser_cnt;
  logic              r_wr;

  logic              w_take;
  logic              w_addr_bit;
  logic              w_data_bit;
  logic              w_addr_last;
  logic              w_addr_valid;
  logic              w_data_valid;
  bus_mode_e         w_mode;

  logic              w_mem_ack;
  logic              w_mem_ready;
  logic              w_mem_rd_valid;
  logic [DATA_W-1:0] w_mem_rd_data;

  assign w_mode = bus_mode_e'(bus_mode);
  assign w_take = decoder_valid & bus_data_in_valid & w_mem_ready &
                  (r_state inside {IDLE, ADDR, DATA});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_addr_bit   = 1'b0;
    w_data_bit   = 1'b0;
    w_addr_last  = 1'b0;
    w_addr_valid = 1'b0;
    w_data_valid = 1'b0;
    case (r_state)
      IDLE, ADDR: begin
        if (!decoder_valid) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (w_take) begin
          if (w_mode == MODE_DATA) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_addr_bit = 1'b1;
            if (r_cnt == CNT_W'(ADDR_W - 1)) begin
              w_addr_last = 1'b1;
              w_cnt_nxt   = '0;
              w_state_nxt = target_rw ? DATA : REQ;
            end else begin
              w_cnt_nxt   = r_cnt + 1'b1;
              w_state_nxt = ADDR;
            end
          end
        end
      end
      DATA: begin
        if (!decoder_valid) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (w_take) begin
          if (w_mode == MODE_ADDR) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_data_bit = 1'b1;
            if (r_cnt == CNT_W'(DATA_W - 1)) begin
              w_cnt_nxt   = '0;
              w_state_nxt = REQ;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
        end
      end
      REQ: begin
        w_addr_valid = 1'b1;
        w_data_valid = r_wr;
        w_state_nxt  = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (w_mem_ack) begin
          w_state_nxt = r_wr ? IDLE : SHIFT_OUT;
        end
      end
      SHIFT_OUT: begin
        if (r_ser_cnt == SER_W'(DATA_W - 1)) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_ser_byte <= '0;
      r_ser_cnt  <= '0;
      r_wr       <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_addr_bit) begin
        r_addr[r_cnt] <= bus_data_in;
      end
      if (w_addr_last) begin
        r_wr <= target_rw;
      end
      if (w_data_bit) begin
        r_wdata[r_cnt[SER_W-1:0]] <= bus_data_in;
      end
      if (w_mem_rd_valid) begin
        r_ser_byte <= w_mem_rd_data;
        r_ser_cnt  <= '0;
      end else if (r_state == SHIFT_OUT) begin
        r_ser_cnt <= r_ser_cnt + 1'b1;
      end
    end
  end

  // Upper address bits alias onto the smaller memory.
  generate
    if (INTERNAL_ADDR_BITS < ADDR_W) begin : g_addr_alias
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = ^r_addr[ADDR_W-1:INTERNAL_ADDR_BITS];
    end
  endgenerate

  target_mem #(
    .INTERNAL_ADDR_BITS(INTERNAL_ADDR_BITS)
  ) u_mem (
    .clk           (clk),
    .rst_n         (rst_n),
    .addr_valid    (w_addr_valid),
    .data_valid    (w_data_valid),
    .rw            (target_rw),
    .addr          (r_addr[INTERNAL_ADDR_BITS-1:0]),
    .data_in       (r_wdata),
    .ack           (w_mem_ack),
    .ready         (w_mem_ready),
    .data_out      (w_mem_rd_data),
    .data_out_valid(w_mem_rd_valid)
  );

  assign bus_data_out_valid = (r_state == SHIFT_OUT);
  assign bus_data_out       = (r_state == SHIFT_OUT) & r_ser_byte[r_ser_cnt];
  assign bus_target_ready   = w_mem_ready;
  assign bus_target_rw      = target_rw;
  assign bus_target_ack     = w_mem_ack;

endmodule

`default_nettype wire

// File: tb/tb_serial_target.sv
// ============================================================================
// Module  : tb_serial_target
// Brief   : Self-checking bench for serial_target: table of serial write/read
//           transactions plus reset and abort sequences.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_target;

  logic clk = 1'b0;
  logic rst_n;
  logic decoder_valid;
  logic bus_data_in;
  logic bus_data_in_valid;
  logic bus_mode;
  logic target_rw;
  logic bus_data_out;
  logic bus_data_out_valid;
  logic bus_target_ready;
  logic bus_target_rw;
  logic bus_target_ack;

  serial_target #(
    .INTERNAL_ADDR_BITS(11)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .decoder_valid     (decoder_valid),
    .bus_data_in       (bus_data_in),
    .bus_data_in_valid (bus_data_in_valid),
    .bus_mode          (bus_mode),
    .target_rw         (target_rw),
    .bus_data_out      (bus_data_out),
    .bus_data_out_valid(bus_data_out_valid),
    .bus_target_ready  (bus_target_ready),
    .bus_target_rw     (bus_target_rw),
    .bus_target_ack    (bus_target_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Monitor state, written only by the monitor process
  int         cyc = 0;
  int         ack_total = 0;
  int         beat_total = 0;
  int         pt_bad = 0;
  int         ack_cyc = 0;
  logic       ack_rw = 1'b0;
  int         out_first = 0;
  int         out_last = 0;
  logic       prev_ov = 1'b0;
  logic [7:0] out_shift = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus_target_rw !== target_rw || bus_target_ready !== ~bus_target_ack)
      pt_bad <= pt_bad + 1;
    if (bus_target_ack === 1'b1) begin
      ack_total <= ack_total + 1;
      ack_cyc   <= cyc;
      ack_rw    <= bus_target_rw;
    end
    if (bus_data_out_valid === 1'b1) begin
      if (!prev_ov) out_first <= cyc;
      out_last   <= cyc;
      beat_total <= beat_total + 1;
      out_shift  <= {bus_data_out, out_shift[7:1]};
    end
    prev_ov <= bus_data_out_valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic dv, input logic v, input logic mode, input logic b);
    decoder_valid     = dv;
    bus_data_in_valid = v;
    bus_mode          = mode;
    bus_data_in       = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_addr(input logic [15:0] a, input int n, input logic dv,
                           input logic gap, output int last);
    last = 0;
    for (int i = 0; i < n; i++) begin
      if (gap && i == 7) begin
        drive(dv, 1'b0, 1'b0, 1'b0);
        drive(dv, 1'b0, 1'b0, 1'b0);
      end
      last = cyc;
      drive(dv, 1'b1, 1'b0, a[i]);
    end
  endtask

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        dv;
    logic        gap;
    int          exp_acks;
    logic [7:0]  exp_rdata;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    int a0, b0, last;
    a0 = ack_total;
    b0 = beat_total;
    target_rw = v.rw;
    send_addr(v.addr, 16, v.dv, v.gap, last);
    if (v.rw) begin
      drive(v.dv, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
        if (v.gap && i == 3) drive(v.dv, 1'b0, 1'b1, 1'b0);
        last = cyc;
        drive(v.dv, 1'b1, 1'b1, v.wdata[i]);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (14) @(posedge clk);
    #1;
    check({tag, " ack_count"}, 32'(ack_total - a0), 32'(v.exp_acks));
    check({tag, " beats"}, 32'(beat_total - b0),
          32'((v.exp_acks == 1 && !v.rw) ? 8 : 0));
    if (v.exp_acks == 1) begin
      check({tag, " ack_rw"}, 32'(ack_rw), 32'(v.rw));
      check({tag, " ack_cycle"}, 32'(ack_cyc), 32'(last + 2));
      if (!v.rw) begin
        check({tag, " rdata"}, 32'(out_shift), 32'(v.exp_rdata));
        check({tag, " out_first"}, 32'(out_first), 32'(last + 3));
        check({tag, " out_last"}, 32'(out_last), 32'(last + 10));
      end
    end
    check({tag, " passthrough"}, 32'(pt_bad), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " data_out"}, 32'(bus_data_out), 32'd0);
    check({tag, " data_out_valid"}, 32'(bus_data_out_valid), 32'd0);
    check({tag, " ack"}, 32'(bus_target_ack), 32'd0);
    check({tag, " ready"}, 32'(bus_target_ready), 32'd1);
  endtask

  vec_t vecs[10];

  initial begin
    int   last, a0;
    vec_t v;

    //            rw    addr       wdata  dv    gap   acks rdata
    vecs[0] = '{1'b1, 16'h0532, 8'h9E, 1'b1, 1'b0, 1, 8'h00};
    vecs[1] = '{1'b0, 16'h0532, 8'h00, 1'b1, 1'b0, 1, 8'h9E};
    vecs[2] = '{1'b1, 16'h0D32, 8'h5A, 1'b1, 1'b1, 1, 8'h00};
    vecs[3] = '{1'b0, 16'h0532, 8'h00, 1'b1, 1'b1, 1, 8'h5A};
    vecs[4] = '{1'b1, 16'h0532, 8'h11, 1'b0, 1'b0, 0, 8'h00};
    vecs[5] = '{1'b0, 16'h0532, 8'h00, 1'b1, 1'b0, 1, 8'h5A};
    vecs[6] = '{1'b1, 16'h07FF, 8'hA5, 1'b1, 1'b0, 1, 8'h00};
    vecs[7] = '{1'b0, 16'hF7FF, 8'h00, 1'b1, 1'b0, 1, 8'hA5};
    vecs[8] = '{1'b1, 16'h0000, 8'h01, 1'b1, 1'b0, 1, 8'h00};
    vecs[9] = '{1'b0, 16'h0800, 8'h00, 1'b1, 1'b1, 1, 8'h01};

    rst_n             = 1'b0;
    decoder_valid     = 1'b0;
    bus_data_in       = 1'b0;
    bus_data_in_valid = 1'b0;
    bus_mode          = 1'b0;
    target_rw         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("post_reset");

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Data bit before the address completes aborts the frame
    a0 = ack_total;
    target_rw = 1'b1;
    send_addr(16'h0532, 5, 1'b1, 1'b0, last);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("abort no_ack", 32'(ack_total - a0), 32'd0);
    v = '{1'b0, 16'h0532, 8'h00, 1'b1, 1'b0, 1, 8'h5A};
    run_vec(v, "abort_read");

    // Reset in the middle of an address frame
    a0 = ack_total;
    target_rw = 1'b0;
    send_addr(16'h0532, 10, 1'b1, 1'b0, last);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check_idle_outputs("mid_reset");
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("mid_reset no_ack", 32'(ack_total - a0), 32'd0);
`ifdef SERIAL_TARGET_MEM_CLEAR_EN
    v = '{1'b0, 16'h0100, 8'h00, 1'b1, 1'b0, 1, 8'h00};
    run_vec(v, "cleared_read");
`endif
    v = '{1'b1, 16'h0532, 8'h7E, 1'b1, 1'b0, 1, 8'h00};
    run_vec(v, "post_rst_write");
    v = '{1'b0, 16'h0532, 8'h00, 1'b1, 1'b0, 1, 8'h7E};
    run_vec(v, "post_rst_read");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
